// File: rtl/axis_bram_streamer.sv
// Streams a (start_addr, length) window of a complex-sample BRAM as sign-extended {real, imag} AXI-Stream beats.
// Optional: define AXIS_BRAM_TUSER_EN to add m_axis_tuser carrying each beat's BRAM address.
module axis_bram_streamer #(
  parameter int DATA_WIDTH   = 32,
  parameter int OUT_WIDTH    = 64,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH:0]     length,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   mem_raddr,
  output logic                    mem_clken,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [OUT_WIDTH-1:0]    m_axis_tdata,
  output logic                    m_axis_tlast,
`ifdef AXIS_BRAM_TUSER_EN
  output logic [ADDR_WIDTH-1:0]   m_axis_tuser,
`endif
  output logic [OUT_WIDTH/8-1:0]  m_axis_tkeep
);

  localparam int HW   = DATA_WIDTH / 2;
  localparam int OHW  = OUT_WIDTH / 2;
  localparam int TAIL = READ_LATENCY - 1;
  localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [READ_LATENCY-1:0] last_q, last_d;
  logic                    issue;
`ifdef AXIS_BRAM_TUSER_EN
  logic [ADDR_WIDTH-1:0]   tag_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]   tag_d [READ_LATENCY];
`endif

  // The tail of the valid/last pipe lines up with BRAM rdata because both advance on mem_clken.
  assign m_axis_tvalid = vld_q[TAIL];
  assign m_axis_tlast  = vld_q[TAIL] & last_q[TAIL];
  assign m_axis_tkeep  = '1;
  assign mem_clken     = !(m_axis_tvalid && !m_axis_tready);
  assign mem_raddr     = raddr_q;
  assign busy          = (state_q != S_IDLE);
`ifdef AXIS_BRAM_TUSER_EN
  assign m_axis_tuser  = tag_q[TAIL];
`endif

  logic [HW-1:0] re_half, im_half;
  assign re_half = mem_rdata[DATA_WIDTH-1:HW];
  assign im_half = mem_rdata[HW-1:0];

  for (genvar b = 0; b < OHW; b++) begin : g_sext
    if (b < HW) begin : g_bit
      assign m_axis_tdata[OHW+b] = re_half[b];
      assign m_axis_tdata[b]     = im_half[b];
    end else begin : g_ext
      assign m_axis_tdata[OHW+b] = re_half[HW-1];
      assign m_axis_tdata[b]     = im_half[HW-1];
    end
  end

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    rem_d   = rem_q;
    vld_d   = vld_q;
    last_d  = last_q;
    issue   = 1'b0;
`ifdef AXIS_BRAM_TUSER_EN
    tag_d   = tag_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (go && (length != '0)) begin
          raddr_d = start_addr;
          rem_d   = length;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_clken) begin
          issue   = 1'b1;
          raddr_d = raddr_q + ADDR_WIDTH'(1);
          rem_d   = rem_q - REM_ONE;
          if (rem_q == REM_ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Whole pipe freezes on a stall so BRAM output and its tags never slip apart.
    if (mem_clken) begin
      vld_d[0]  = issue;
      last_d[0] = issue && (rem_q == REM_ONE);
`ifdef AXIS_BRAM_TUSER_EN
      tag_d[0]  = raddr_q;
`endif
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_d[i]  = vld_q[i-1];
        last_d[i] = last_q[i-1];
`ifdef AXIS_BRAM_TUSER_EN
        tag_d[i]  = tag_q[i-1];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      rem_q   <= '0;
      vld_q   <= '0;
      last_q  <= '0;
`ifdef AXIS_BRAM_TUSER_EN
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
`endif
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
`ifdef AXIS_BRAM_TUSER_EN
      tag_q   <= tag_d;
`endif
    end
  end

endmodule

// File: tb/tb_axis_bram_streamer.sv
// Bench for axis_bram_streamer: four instances (READ_LATENCY 1..4) share stimulus; each has its own BRAM model and beat recorder.
module tb_axis_bram_streamer;

  typedef struct packed {
    logic [63:0] dat;
    logic        last;
    logic [11:0] user;
    int          cyc;
  } rec_t;

  typedef struct packed {
    int n;
    int stab;
    int vcnt;
    int bcnt;
    int blast;
    int stalls;
    int nlast;
  } stat_t;

  localparam int TMO = 6000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [11:0] start_addr = '0;
  logic [12:0] length = '0;
  logic        tready = 1'b1;
  logic        cap_clr = 1'b0;
  int          cyc = 0;
  int          asserts = 0;
  int          failures = 0;

  logic        busy_a   [4];
  logic        tvalid_a [4];
  logic        tlast_a  [4];
  logic        clken_a  [4];
  logic [11:0] raddr_a  [4];
  logic [31:0] rdata_a  [4];
  logic [63:0] tdata_a  [4];
  logic [7:0]  tkeep_a  [4];
`ifdef AXIS_BRAM_TUSER_EN
  logic [11:0] user_a   [4];
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(logic [11:0] a);
    logic [15:0] re;
    re = {4'b0000, a};
    return {re, ~re};
  endfunction

  function automatic logic [63:0] exp_dat(logic [11:0] a);
    logic [15:0] re, im;
    re = {4'b0000, a};
    im = ~re;
    return {{16{re[15]}}, re, {16{im[15]}}, im};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gi
    logic [31:0] pipe [g+1];
    rec_t        recs [4096];
    stat_t       st;
    logic        pend = 1'b0;
    logic        plast;
    logic [63:0] pdat;
    rec_t        r;

    axis_bram_streamer #(
      .DATA_WIDTH(32), .OUT_WIDTH(64), .ADDR_WIDTH(12), .READ_LATENCY(g + 1)
    ) dut (
      .clk(clk), .reset(reset), .go(go), .start_addr(start_addr), .length(length),
      .busy(busy_a[g]), .mem_raddr(raddr_a[g]), .mem_clken(clken_a[g]), .mem_rdata(rdata_a[g]),
      .m_axis_tvalid(tvalid_a[g]), .m_axis_tready(tready), .m_axis_tdata(tdata_a[g]),
      .m_axis_tlast(tlast_a[g]),
`ifdef AXIS_BRAM_TUSER_EN
      .m_axis_tuser(user_a[g]),
`endif
      .m_axis_tkeep(tkeep_a[g])
    );

    assign rdata_a[g] = pipe[g];

    always @(posedge clk) begin
      if (clken_a[g]) begin
        pipe[0] <= mem_word(raddr_a[g]);
        for (int j = 1; j <= g; j++) pipe[j] <= pipe[j-1];
      end
    end

    always @(negedge clk) begin
      if (cap_clr) begin
        st   = '0;
        pend = 1'b0;
      end else begin
        if (tvalid_a[g] && tready) begin
          r.dat  = tdata_a[g];
          r.last = tlast_a[g];
`ifdef AXIS_BRAM_TUSER_EN
          r.user = user_a[g];
`else
          r.user = '0;
`endif
          r.cyc  = cyc;
          if (st.n < 4096) recs[st.n] = r;
          st.n++;
          if (tlast_a[g]) st.nlast++;
        end
        if (tvalid_a[g]) st.vcnt++;
        if (tvalid_a[g] && !tready) st.stalls++;
        if (busy_a[g]) begin
          st.bcnt++;
          st.blast = cyc;
        end
        if (pend && (!tvalid_a[g] || tdata_a[g] !== pdat || tlast_a[g] !== plast)) st.stab++;
        pend  = tvalid_a[g] && !tready;
        pdat  = tdata_a[g];
        plast = tlast_a[g];
      end
    end
  end

  function automatic rec_t get_rec(int k, int i);
    case (k)
      0:       return gi[0].recs[i];
      1:       return gi[1].recs[i];
      2:       return gi[2].recs[i];
      default: return gi[3].recs[i];
    endcase
  endfunction

  function automatic stat_t get_stat(int k);
    case (k)
      0:       return gi[0].st;
      1:       return gi[1].st;
      2:       return gi[2].st;
      default: return gi[3].st;
    endcase
  endfunction

  // Clears recorders, issues go at relative cycle 0, runs until every instance is idle.
  task automatic run_window(input logic [11:0] sa, input logic [12:0] len, input int mode,
                            input int inj_cyc, input logic [11:0] isa, input logic [12:0] ilen,
                            input int rst_cyc, output int k0, output bit to,
                            output logic [3:0] svld, output logic [3:0] sbusy);
    bit idle;
    to = 1'b1;
    svld = '0;
    sbusy = '0;
    @(posedge clk); #1;
    cap_clr = 1'b1;
    @(posedge clk); #1;
    cap_clr = 1'b0;
    go = 1'b1;
    start_addr = sa;
    length = len;
    tready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
    k0 = cyc;
    for (int c = 1; c < TMO; c++) begin
      @(posedge clk); #1;
      go = (c == inj_cyc);
      if (c == inj_cyc) begin
        start_addr = isa;
        length = ilen;
      end
      if (c == rst_cyc) reset = 1'b1;
      if (rst_cyc != 0 && c == rst_cyc + 1) begin
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
          svld[k]  = tvalid_a[k];
          sbusy[k] = busy_a[k];
        end
      end
      tready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
      idle = 1'b1;
      for (int k = 0; k < 4; k++) if (busy_a[k]) idle = 1'b0;
      if (c > 2 && idle) begin
        to = 1'b0;
        break;
      end
    end
    go = 1'b0;
    reset = 1'b0;
    tready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      asserts++; if (busy_a[k] !== 1'b0) begin failures++; $display("FAIL reset_busy rl=%0d got %b required 0", k+1, busy_a[k]); end
      asserts++; if (tvalid_a[k] !== 1'b0) begin failures++; $display("FAIL reset_tvalid rl=%0d got %b required 0", k+1, tvalid_a[k]); end
      asserts++; if (tlast_a[k] !== 1'b0) begin failures++; $display("FAIL reset_tlast rl=%0d got %b required 0", k+1, tlast_a[k]); end
      asserts++; if (clken_a[k] !== 1'b1) begin failures++; $display("FAIL reset_clken rl=%0d got %b required 1", k+1, clken_a[k]); end
      asserts++; if (raddr_a[k] !== 12'd0) begin failures++; $display("FAIL reset_raddr rl=%0d got %0d required 0", k+1, raddr_a[k]); end
      asserts++; if (tkeep_a[k] !== 8'hFF) begin failures++; $display("FAIL reset_tkeep rl=%0d got %h required ff", k+1, tkeep_a[k]); end
    end
    reset = 1'b0;
  endtask

  task automatic test_smoke();
    int k0, bad, first;
    bit to;
    logic [3:0] sv, sb;
    rec_t r;
    stat_t s;
    run_window(12'd0, 13'd2048, 0, 0, 12'd0, 13'd0, 0, k0, to, sv, sb);
    asserts++; if (to) begin failures++; $display("FAIL smoke_timeout busy still high after %0d cycles, required idle", TMO); end
    for (int k = 0; k < 4; k++) begin
      s = get_stat(k);
      bad = 0; first = -1;
      for (int i = 0; i < 2048; i++) begin
        r = get_rec(k, i);
        if (r.dat !== exp_dat(12'(i)) || r.last !== (i == 2047) || (r.cyc - k0) !== (2 + k + i)) begin
          bad++; if (first < 0) first = i;
        end
      end
      asserts++; if (s.n !== 2048) begin failures++; $display("FAIL smoke_count rl=%0d got %0d beats required 2048", k+1, s.n); end
      asserts++; if (bad !== 0) begin failures++; $display("FAIL smoke_beats rl=%0d got %0d bad beats (first %0d) required 0", k+1, bad, first); end
      asserts++; if (s.nlast !== 1) begin failures++; $display("FAIL smoke_tlast_count rl=%0d got %0d required 1", k+1, s.nlast); end
      asserts++; if (s.blast - k0 + 1 !== 2048 + k + 2) begin failures++; $display("FAIL smoke_busy_fall rl=%0d got cycle %0d required %0d", k+1, s.blast - k0 + 1, 2048 + k + 2); end
    end
  endtask

  task automatic test_wrap();
    int k0, bad;
    bit to;
    logic [3:0] sv, sb;
    logic [11:0] a;
    rec_t r;
    stat_t s;
    run_window(12'd4094, 13'd4, 0, 0, 12'd0, 13'd0, 0, k0, to, sv, sb);
    asserts++; if (to) begin failures++; $display("FAIL wrap_timeout busy still high, required idle"); end
    for (int k = 0; k < 4; k++) begin
      s = get_stat(k);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        r = get_rec(k, i);
        a = 12'(4094 + i);
        if (r.dat !== exp_dat(a) || r.last !== (i == 3)) bad++;
`ifdef AXIS_BRAM_TUSER_EN
        if (r.user !== a) bad++;
`endif
      end
      asserts++; if (s.n !== 4) begin failures++; $display("FAIL wrap_count rl=%0d got %0d required 4", k+1, s.n); end
      asserts++; if (bad !== 0) begin failures++; $display("FAIL wrap_beats rl=%0d got %0d bad fields required 0", k+1, bad); end
    end
  endtask

  task automatic test_backpressure();
    int k0, bad;
    bit to;
    logic [3:0] sv, sb;
    rec_t r;
    stat_t s;
    run_window(12'd123, 13'd100, 1, 0, 12'd0, 13'd0, 0, k0, to, sv, sb);
    asserts++; if (to) begin failures++; $display("FAIL bp_timeout busy still high, required idle"); end
    for (int k = 0; k < 4; k++) begin
      s = get_stat(k);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
        r = get_rec(k, i);
        if (r.dat !== exp_dat(12'(123 + i)) || r.last !== (i == 99)) bad++;
      end
      r = get_rec(k, 99);
      asserts++; if (s.n !== 100) begin failures++; $display("FAIL bp_count rl=%0d got %0d required 100", k+1, s.n); end
      asserts++; if (bad !== 0) begin failures++; $display("FAIL bp_order rl=%0d got %0d bad beats required 0", k+1, bad); end
      asserts++; if (s.stab !== 0) begin failures++; $display("FAIL bp_stable rl=%0d got %0d changes while stalled required 0", k+1, s.stab); end
      asserts++; if (r.cyc - k0 !== 100 + k + 1 + s.stalls) begin failures++; $display("FAIL bp_stall_cost rl=%0d got tlast cycle %0d required %0d", k+1, r.cyc - k0, 100 + k + 1 + s.stalls); end
    end
  endtask

  task automatic test_length_edges();
    int k0, bad;
    bit to;
    logic [3:0] sv, sb;
    rec_t r;
    stat_t s;
    run_window(12'd9, 13'd0, 0, 0, 12'd0, 13'd0, 0, k0, to, sv, sb);
    asserts++; if (to) begin failures++; $display("FAIL len0_timeout busy still high, required idle"); end
    for (int k = 0; k < 4; k++) begin
      s = get_stat(k);
      asserts++; if (s.bcnt !== 0 || s.vcnt !== 0) begin failures++; $display("FAIL len0_idle rl=%0d got busy %0d tvalid %0d cycles required 0 0", k+1, s.bcnt, s.vcnt); end
    end
    run_window(12'd77, 13'd1, 0, 0, 12'd0, 13'd0, 0, k0, to, sv, sb);
    asserts++; if (to) begin failures++; $display("FAIL len1_timeout busy still high, required idle"); end
    for (int k = 0; k < 4; k++) begin
      s = get_stat(k);
      r = get_rec(k, 0);
      asserts++; if (s.n !== 1 || r.dat !== exp_dat(12'd77) || r.last !== 1'b1 || r.cyc - k0 !== k + 2) begin
        failures++; $display("FAIL len1_beat rl=%0d got n=%0d dat=%h last=%b cyc=%0d required n=1 dat=%h last=1 cyc=%0d",
                             k+1, s.n, r.dat, r.last, r.cyc - k0, exp_dat(12'd77), k + 2);
      end
    end
    run_window(12'd5, 13'd4096, 0, 0, 12'd0, 13'd0, 0, k0, to, sv, sb);
    asserts++; if (to) begin failures++; $display("FAIL len4096_timeout busy still high, required idle"); end
    for (int k = 0; k < 4; k++) begin
      s = get_stat(k);
      bad = 0;
      for (int i = 0; i < 4096; i++) begin
        r = get_rec(k, i);
        if (r.dat !== exp_dat(12'(5 + i)) || r.last !== (i == 4095)) bad++;
      end
      asserts++; if (s.n !== 4096 || bad !== 0) begin failures++; $display("FAIL len4096 rl=%0d got %0d beats %0d bad required 4096 beats 0 bad", k+1, s.n, bad); end
    end
  endtask

  task automatic test_go_busy();
    int k0, bad;
    bit to;
    logic [3:0] sv, sb;
    rec_t r;
    stat_t s;
    run_window(12'd200, 13'd60, 0, 12, 12'd900, 13'd5, 0, k0, to, sv, sb);
    asserts++; if (to) begin failures++; $display("FAIL gobusy_timeout busy still high, required idle"); end
    for (int k = 0; k < 4; k++) begin
      s = get_stat(k);
      bad = 0;
      for (int i = 0; i < 60; i++) begin
        r = get_rec(k, i);
        if (r.dat !== exp_dat(12'(200 + i)) || r.last !== (i == 59)) bad++;
      end
      asserts++; if (s.n !== 60 || bad !== 0 || s.nlast !== 1) begin
        failures++; $display("FAIL gobusy rl=%0d got %0d beats %0d bad %0d tlast required 60 0 1", k+1, s.n, bad, s.nlast);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k0, bad;
    bit to;
    logic [3:0] sv, sb;
    rec_t r;
    stat_t s;
    run_window(12'd300, 13'd100, 0, 0, 12'd0, 13'd0, 52, k0, to, sv, sb);
    asserts++; if (to) begin failures++; $display("FAIL rstmid_timeout busy still high, required idle"); end
    asserts++; if (sv !== 4'b0000) begin failures++; $display("FAIL rstmid_tvalid got %b required 0000", sv); end
    asserts++; if (sb !== 4'b0000) begin failures++; $display("FAIL rstmid_busy got %b required 0000", sb); end
    for (int k = 0; k < 4; k++) begin
      s = get_stat(k);
      asserts++; if (s.nlast !== 0 || s.n >= 100) begin failures++; $display("FAIL rstmid_partial rl=%0d got %0d beats %0d tlast required <100 beats 0 tlast", k+1, s.n, s.nlast); end
    end
    run_window(12'd1000, 13'd8, 0, 0, 12'd0, 13'd0, 0, k0, to, sv, sb);
    asserts++; if (to) begin failures++; $display("FAIL rstmid_restart_timeout busy still high, required idle"); end
    for (int k = 0; k < 4; k++) begin
      s = get_stat(k);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        r = get_rec(k, i);
        if (r.dat !== exp_dat(12'(1000 + i)) || r.last !== (i == 7) || r.cyc - k0 !== k + 2 + i) bad++;
      end
      asserts++; if (s.n !== 8 || bad !== 0) begin failures++; $display("FAIL rstmid_restart rl=%0d got %0d beats %0d bad required 8 beats 0 bad", k+1, s.n, bad); end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_smoke();
    test_wrap();
    test_backpressure();
    test_length_edges();
    test_go_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/axis_bram_streamer.md
# axis_bram_streamer

Parametrised BRAM-to-AXI-Stream reader that replaces the fixed-size, fixed-latency FFT result master. On a go pulse it streams an arbitrary window of a complex sample BRAM (start address, length) as packed, sign-extended real/imag beats. It supports any BRAM read latency from 1 to 4 and fully stalls the read pipeline under back-pressure. It sits between the FFT result memory and the output DMA/stream fabric.

## Interface
Parameters:
- DATA_WIDTH, 32: BRAM word width. Upper half is real, lower half is imag. Must be even.
- OUT_WIDTH, 64: AXIS tdata width. Must be ≥ DATA_WIDTH, even, and a multiple of 8.
- ADDR_WIDTH, 12: BRAM address width.
- READ_LATENCY, 2: clken-gated cycles from raddr to valid rdata. Legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- go  in  1  start pulse, sampled only in IDLE
- start_addr  in  ADDR_WIDTH  first address, sampled with go
- length  in  ADDR_WIDTH+1  beat count, 0..2^ADDR_WIDTH, sampled with go
- busy  out  1  high whenever state ≠ IDLE
- mem_raddr  out  ADDR_WIDTH  BRAM read address
- mem_clken  out  1  BRAM and read-pipeline clock enable
- mem_rdata  in  DATA_WIDTH  BRAM read data
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tdata  out  OUT_WIDTH  {sext(real), sext(imag)}, each OUT_WIDTH/2 bits
- m_axis_tlast  out  1  final beat of the window
- m_axis_tkeep  out  OUT_WIDTH/8  tied all-ones

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - go with length ≠ 0: latch raddr = start_addr and remaining = length, go to ISSUE.
  - go with length = 0: ignored. busy stays low and no beats are produced.
- ISSUE: each cycle with mem_clken = 1 is one read issue.
  - Push valid = 1 and last = (remaining == 1) into a READ_LATENCY-deep shift register.
  - raddr += 1, wrapping modulo 2^ADDR_WIDTH. Window wraps through address 0.
  - remaining -= 1.
  - On the issue where remaining == 1, go to DRAIN.
- DRAIN: no issues. Valid 0 is shifted in on each enabled cycle. When the tlast beat handshakes, go to IDLE.
- mem_clken = !(m_axis_tvalid && !m_axis_tready). When low, raddr, remaining, the shift register and the BRAM output all hold.
- Outputs from the shift-register tail:
  - m_axis_tvalid = tail valid.
  - m_axis_tlast = tail valid && tail last.
  - tdata is mem_rdata split into halves, each sign-extended.
- go while busy is ignored. start_addr and length are not re-sampled.
- mem_raddr holds its last value in IDLE. It is don't-care for the BRAM because no valid is issued.

## Timing
- Reset values: state IDLE, busy 0, tvalid 0, tlast 0, shift register all 0, mem_clken 1, mem_raddr 0.
- Reset mid-transfer: tvalid drops the cycle after reset is sampled. The partial window is discarded and no tlast is emitted.
- go sampled at cycle 0:
  - busy = 1 and mem_raddr = start_addr from cycle 1.
  - First tvalid at cycle 1+READ_LATENCY.
- Throughput: one beat per cycle while tready = 1.
- With tready held high and length L: tlast at cycle L+READ_LATENCY; busy = 0 at cycle L+READ_LATENCY+1.
- tvalid, once high, holds with stable tdata/tlast until handshake (AXIS rule).
- tready toggling: beats are never lost or duplicated. Every tready-low cycle while tvalid is high costs exactly one cycle.
- Earliest next go is the cycle busy reads 0. Back-to-back windows have a gap of READ_LATENCY+1 cycles.

## Configuration
- AXIS_BRAM_TUSER_EN defined:
  - Adds port m_axis_tuser, out, ADDR_WIDTH bits: the BRAM address (bin index) of the current beat.
  - The address travels through the same shift register as valid/last.
  - Follows tdata stability rules.
- Undefined: port and its pipeline storage are absent. All other behaviour is identical.

## Test plan
- Smoke test. READ_LATENCY=2, start 0, length 2048, tready always high, BRAM[a] = {a, ~a} (16/16).
  - Expect 2048 beats with tdata = {sext(a), sext(~a)}.
  - tlast only on beat 2047 at cycle 2050.
  - busy falls at cycle 2051.
- Address wrap. start 4094, length 4, ADDR_WIDTH 12.
  - Expect beat addresses 4094, 4095, 0, 1, checked via tdata (and tuser when AXIS_BRAM_TUSER_EN is defined).
- Back-pressure. tready random at 30% duty, length 100, READ_LATENCY ∈ {1,3,4}.
  - Expect exactly 100 beats in order, no duplicates, and tdata stable while stalled.
- Length edge cases.
  - go with length 0: busy never rises and tvalid is never asserted.
  - length 1: a single beat with tlast = 1.
  - length 4096: full memory streamed.
- go during busy and reset mid-transfer.
  - A second go at beat 10 with different start_addr has no effect.
  - reset at beat 50: tvalid = 0 the next cycle, then a fresh go streams correctly from its own start_addr.
